// File: rtl/half_layer1_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// half_layer1_sequencer_pkg
// Shared definitions for the half-precision layer-1 sequencer: the controller
// state encoding, the 16-bit half word type and the beat-count helpers that
// size the weight and input streaming phases.
// -----------------------------------------------------------------------------
package half_layer1_sequencer_pkg;

    // Controller states, in the order a reload run walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_RUN_X  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // IEEE-754 binary16 word as seen on every data lane.
    typedef logic [15:0] half_t;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned ADDR_W = 16;

    // Parameter-memory beats needed to stream the full W1 matrix.
    function automatic int unsigned w_beats(input int unsigned l1_neurons,
                                            input int unsigned l2_neurons,
                                            input int unsigned mults);
        return (l1_neurons * l2_neurons) / mults;
    endfunction

    // Input-memory beats needed to stream one x vector.
    function automatic int unsigned x_beats(input int unsigned l1_neurons,
                                            input int unsigned mults);
        return l1_neurons / mults;
    endfunction

endpackage

// File: rtl/half_layer1_sequencer_counter.sv
// -----------------------------------------------------------------------------
// half_seq_addr_counter
// Loadable up-counter with a terminal-count flag. Used by the sequencer both
// as the memory read address generator and as the result write counter.
//   clk_i, rstn_i : clock, synchronous active-low reset (count clears to 0)
//   load_i        : load load_val_i (takes priority over en_i)
//   load_val_i    : value to load
//   en_i          : increment by one
//   tc_val_i      : terminal value compared against the current count
//   count_o       : current count
//   tc_o          : high while count_o equals tc_val_i
// -----------------------------------------------------------------------------
module half_seq_addr_counter
    import half_layer1_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] tc_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins over increment.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_val_i);

endmodule

// File: rtl/half_layer1_sequencer.sv
// -----------------------------------------------------------------------------
// half_layer1_sequencer
// Sequencing controller for the half-precision layer-1 predict datapath.
// On an accepted start it optionally streams W1 and b1 from the parameter
// memory, then streams x from the input memory, collects LAYER2_NEURONS
// results into the result buffer and pulses done_o.
// Ports:
//   clk_i, rstn_i            : clock, synchronous active-low reset
//   start_i, reload_i        : run request; reload_i selects weight loading
//   busy_o, done_o, err_o    : status (done_o/err_o are one-cycle pulses)
//   p_rd_o, p_addr_o, p_data_i : parameter memory read port (1-cycle latency)
//   x_rd_o, x_addr_o, x_data_i : input memory read port (1-cycle latency)
//   dp_load_w1_o, dp_load_b1_o, dp_in_valid_o : datapath strobes
//   dp_neuron_data_o, dp_x_o : datapath data lanes, zero when no strobe
//   dp_out_valid_i, dp_layer1_out_i : datapath result
//   res_we_o, res_addr_o, res_data_o : result buffer write port
// -----------------------------------------------------------------------------
module half_layer1_sequencer
    import half_layer1_sequencer_pkg::*;
#(
    parameter int unsigned LAYER1_NEURONS = 10,
    parameter int unsigned LAYER2_NEURONS = 10,
    parameter int unsigned MULTS          = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    reload_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    p_rd_o,
    output logic [ADDR_W-1:0]       p_addr_o,
    input  logic [HALF_W*MULTS-1:0] p_data_i,
    output logic                    x_rd_o,
    output logic [ADDR_W-1:0]       x_addr_o,
    input  logic [HALF_W*MULTS-1:0] x_data_i,
    output logic                    dp_load_w1_o,
    output logic                    dp_load_b1_o,
    output logic                    dp_in_valid_o,
    output logic [HALF_W*MULTS-1:0] dp_neuron_data_o,
    output logic [HALF_W*MULTS-1:0] dp_x_o,
    input  logic                    dp_out_valid_i,
    input  half_t                   dp_layer1_out_i,
    output logic                    res_we_o,
    output logic [ADDR_W-1:0]       res_addr_o,
    output half_t                   res_data_o
);

    localparam int unsigned W_BEATS = w_beats(LAYER1_NEURONS, LAYER2_NEURONS, MULTS);
    localparam int unsigned X_BEATS = x_beats(LAYER1_NEURONS, MULTS);

    localparam logic [ADDR_W-1:0] W_LAST    = ADDR_W'(W_BEATS - 1);
    localparam logic [ADDR_W-1:0] B_FIRST   = ADDR_W'(W_BEATS);
    localparam logic [ADDR_W-1:0] B_LAST    = ADDR_W'(W_BEATS + LAYER2_NEURONS - 1);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(X_BEATS - 1);
    localparam logic [ADDR_W-1:0] RES_TOTAL = ADDR_W'(LAYER2_NEURONS);

    seq_state_e state_q, state_d;

    logic              weights_valid_q;
    logic              wv_set_s;

    logic              addr_load_s;
    logic [ADDR_W-1:0] addr_load_val_s;
    logic              addr_en_s;
    logic [ADDR_W-1:0] addr_tc_val_s;
    logic [ADDR_W-1:0] addr_count_s;
    logic              addr_tc_s;

    logic              res_clr_s;
    logic              res_write_s;
    logic [ADDR_W-1:0] res_count_s;
    logic              res_tc_s;

    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;
    logic              p_rd_q,  p_rd_d;
    logic              x_rd_q,  x_rd_d;
    logic              ld_w1_q, ld_w1_d;
    logic              ld_b1_q, ld_b1_d;
    logic              in_v_q,  in_v_d;
    logic              res_we_q, res_we_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    half_t             res_data_q, res_data_d;

    // Read address: counts through each phase, reloaded at phase boundaries
    // so it already holds the first address when the next phase begins.
    half_seq_addr_counter #(.WIDTH(ADDR_W)) u_addr_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (addr_load_s),
        .load_val_i (addr_load_val_s),
        .en_i       (addr_en_s),
        .tc_val_i   (addr_tc_val_s),
        .count_o    (addr_count_s),
        .tc_o       (addr_tc_s)
    );

    // Result count doubles as the result buffer write address.
    half_seq_addr_counter #(.WIDTH(ADDR_W)) u_res_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (res_clr_s),
        .load_val_i ({ADDR_W{1'b0}}),
        .en_i       (res_write_s),
        .tc_val_i   (RES_TOTAL),
        .count_o    (res_count_s),
        .tc_o       (res_tc_s)
    );

    // Results are only accepted while a run can legitimately produce them.
    assign res_write_s = dp_out_valid_i &&
                         ((state_q == ST_RUN_X) || (state_q == ST_DRAIN));

    // Next-state and counter control.
    always_comb begin
        state_d         = state_q;
        addr_load_s     = 1'b0;
        addr_load_val_s = {ADDR_W{1'b0}};
        addr_en_s       = 1'b0;
        addr_tc_val_s   = {ADDR_W{1'b0}};
        res_clr_s       = 1'b0;
        wv_set_s        = 1'b0;
        err_d           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (reload_i) begin
                        state_d     = ST_LOAD_W;
                        addr_load_s = 1'b1;
                        res_clr_s   = 1'b1;
                    end else if (weights_valid_q) begin
                        state_d     = ST_RUN_X;
                        addr_load_s = 1'b1;
                        res_clr_s   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                addr_tc_val_s = W_LAST;
                if (addr_tc_s) begin
                    state_d         = ST_LOAD_B;
                    addr_load_s     = 1'b1;
                    addr_load_val_s = B_FIRST;
                end else begin
                    addr_en_s = 1'b1;
                end
            end
            ST_LOAD_B: begin
                addr_tc_val_s = B_LAST;
                if (addr_tc_s) begin
                    state_d     = ST_RUN_X;
                    addr_load_s = 1'b1;
                    wv_set_s    = 1'b1;
                end else begin
                    addr_en_s = 1'b1;
                end
            end
            ST_RUN_X: begin
                addr_tc_val_s = X_LAST;
                if (addr_tc_s) begin
                    state_d     = ST_DRAIN;
                    addr_load_s = 1'b1;
                end else begin
                    addr_en_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_tc_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                addr_load_s = 1'b1;
            end
        endcase
    end

    // Output register inputs. Read strobes follow the next state so a read
    // appears in the first cycle of its phase; datapath strobes follow the
    // read issued in the current cycle, landing with the memory data.
    always_comb begin
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        p_rd_d     = (state_d == ST_LOAD_W) || (state_d == ST_LOAD_B);
        x_rd_d     = (state_d == ST_RUN_X);
        ld_w1_d    = p_rd_q && (state_q == ST_LOAD_W);
        ld_b1_d    = p_rd_q && (state_q == ST_LOAD_B);
        in_v_d     = x_rd_q && (state_q == ST_RUN_X);
        res_we_d   = res_write_s;
        res_addr_d = {ADDR_W{1'b0}};
        res_data_d = 16'h0000;
        if (res_write_s) begin
            res_addr_d = res_count_s;
            res_data_d = dp_layer1_out_i;
        end else begin
            res_addr_d = {ADDR_W{1'b0}};
            res_data_d = 16'h0000;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q         <= ST_IDLE;
            weights_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            p_rd_q          <= 1'b0;
            x_rd_q          <= 1'b0;
            ld_w1_q         <= 1'b0;
            ld_b1_q         <= 1'b0;
            in_v_q          <= 1'b0;
            res_we_q        <= 1'b0;
            res_addr_q      <= {ADDR_W{1'b0}};
            res_data_q      <= 16'h0000;
        end else begin
            state_q         <= state_d;
            weights_valid_q <= weights_valid_q | wv_set_s;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            p_rd_q          <= p_rd_d;
            x_rd_q          <= x_rd_d;
            ld_w1_q         <= ld_w1_d;
            ld_b1_q         <= ld_b1_d;
            in_v_q          <= in_v_d;
            res_we_q        <= res_we_d;
            res_addr_q      <= res_addr_d;
            res_data_q      <= res_data_d;
        end
    end

    // Data lanes pass the memory word through only in its strobe cycle.
    always_comb begin
        dp_neuron_data_o = {(HALF_W*MULTS){1'b0}};
        dp_x_o           = {(HALF_W*MULTS){1'b0}};
        if (ld_w1_q || ld_b1_q) begin
            dp_neuron_data_o = p_data_i;
        end else begin
            dp_neuron_data_o = {(HALF_W*MULTS){1'b0}};
        end
        if (in_v_q) begin
            dp_x_o = x_data_i;
        end else begin
            dp_x_o = {(HALF_W*MULTS){1'b0}};
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign p_rd_o        = p_rd_q;
    assign p_addr_o      = p_rd_q ? addr_count_s : {ADDR_W{1'b0}};
    assign x_rd_o        = x_rd_q;
    assign x_addr_o      = x_rd_q ? addr_count_s : {ADDR_W{1'b0}};
    assign dp_load_w1_o  = ld_w1_q;
    assign dp_load_b1_o  = ld_b1_q;
    assign dp_in_valid_o = in_v_q;
    assign res_we_o      = res_we_q;
    assign res_addr_o    = res_addr_q;
    assign res_data_o    = res_data_q;

endmodule

// File: tb/tb_half_layer1_sequencer.sv
// -----------------------------------------------------------------------------
// tb_half_layer1_sequencer
// Directed bench for half_layer1_sequencer with default parameters
// (W_BEATS = 50, X_BEATS = 5). Memories and the datapath are small models
// driven once per cycle from step_cycle; each scenario task checks the
// outputs cycle by cycle against hand-derived windows relative to start.
// -----------------------------------------------------------------------------
module tb_half_layer1_sequencer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic        reload_i;
    logic        busy_o, done_o, err_o;
    logic        p_rd_o, x_rd_o;
    logic [15:0] p_addr_o, x_addr_o;
    logic [31:0] p_data_i, x_data_i;
    logic        dp_load_w1_o, dp_load_b1_o, dp_in_valid_o;
    logic [31:0] dp_neuron_data_o, dp_x_o;
    logic        dp_out_valid_i;
    logic [15:0] dp_layer1_out_i;
    logic        res_we_o;
    logic [15:0] res_addr_o, res_data_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int run_id  = 0;

    // Memory / datapath model state
    logic        prev_p_rd = 1'b0, prev_x_rd = 1'b0;
    logic [15:0] prev_p_addr = 16'h0, prev_x_addr = 16'h0;
    int          pend = 0;
    int          xbeats = 0;

    half_layer1_sequencer dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .start_i          (start_i),
        .reload_i         (reload_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .p_rd_o           (p_rd_o),
        .p_addr_o         (p_addr_o),
        .p_data_i         (p_data_i),
        .x_rd_o           (x_rd_o),
        .x_addr_o         (x_addr_o),
        .x_data_i         (x_data_i),
        .dp_load_w1_o     (dp_load_w1_o),
        .dp_load_b1_o     (dp_load_b1_o),
        .dp_in_valid_o    (dp_in_valid_o),
        .dp_neuron_data_o (dp_neuron_data_o),
        .dp_x_o           (dp_x_o),
        .dp_out_valid_i   (dp_out_valid_i),
        .dp_layer1_out_i  (dp_layer1_out_i),
        .res_we_o         (res_we_o),
        .res_addr_o       (res_addr_o),
        .res_data_o       (res_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] p_word(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {16'hA000 | a16, 16'h5000 | a16};
    endfunction

    function automatic logic [31:0] x_word(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {16'hC000 | a16, 16'h3000 | a16};
    endfunction

    function automatic logic [15:0] res_val(input int r, input int i);
        return 16'h3C00 ^ 16'(r * 16 + i);
    endfunction

    // Advance one clock and update the memory and datapath models.
    task automatic step_cycle();
        @(posedge clk_i);
        #1;
        if (!rstn_i) begin
            pend   = 0;
            xbeats = 0;
        end
        p_data_i    = prev_p_rd ? p_word(int'(prev_p_addr)) : 32'hDEAD_BEEF;
        x_data_i    = prev_x_rd ? x_word(int'(prev_x_addr)) : 32'hFACE_CAFE;
        prev_p_rd   = p_rd_o;
        prev_p_addr = p_addr_o;
        prev_x_rd   = x_rd_o;
        prev_x_addr = x_addr_o;
        if (pend > 0) begin
            dp_out_valid_i  = 1'b1;
            dp_layer1_out_i = res_val(run_id, 10 - pend);
            pend--;
        end else begin
            dp_out_valid_i  = 1'b0;
            dp_layer1_out_i = 16'h0000;
        end
        if (dp_in_valid_o) begin
            xbeats++;
            if (xbeats == 5) begin
                pend   = 10;
                xbeats = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) step_cycle();
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset.busy got %b exp 0", busy_o); end
        vec_cnt++; if (done_o !== 1'b0) begin err_cnt++; $display("FAIL reset.done got %b exp 0", done_o); end
        vec_cnt++; if (err_o !== 1'b0) begin err_cnt++; $display("FAIL reset.err got %b exp 0", err_o); end
        vec_cnt++; if ({p_rd_o, x_rd_o, dp_load_w1_o, dp_load_b1_o, dp_in_valid_o, res_we_o} !== 6'b0) begin
            err_cnt++; $display("FAIL reset.strobes got %b exp 000000",
                {p_rd_o, x_rd_o, dp_load_w1_o, dp_load_b1_o, dp_in_valid_o, res_we_o}); end
        vec_cnt++; if ({p_addr_o, x_addr_o, res_addr_o, res_data_o} !== 64'h0) begin
            err_cnt++; $display("FAIL reset.addr_data got %h exp 0", {p_addr_o, x_addr_o, res_addr_o, res_data_o}); end
        vec_cnt++; if ({dp_neuron_data_o, dp_x_o} !== 64'h0) begin
            err_cnt++; $display("FAIL reset.lanes got %h exp 0", {dp_neuron_data_o, dp_x_o}); end
        rstn_i = 1'b1;
        step_cycle();
    endtask

    task automatic test_err_no_weights(input string tag);
        start_i  = 1'b1;
        reload_i = 1'b0;
        step_cycle();
        start_i = 1'b0;
        vec_cnt++; if (err_o !== 1'b1) begin err_cnt++; $display("FAIL %s.err_pulse got %b exp 1", tag, err_o); end
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL %s.busy got %b exp 0", tag, busy_o); end
        vec_cnt++; if ({p_rd_o, x_rd_o} !== 2'b00) begin err_cnt++; $display("FAIL %s.reads got %b exp 00", tag, {p_rd_o, x_rd_o}); end
        step_cycle();
        vec_cnt++; if (err_o !== 1'b0) begin err_cnt++; $display("FAIL %s.err_clear got %b exp 0", tag, err_o); end
        vec_cnt++; if ({busy_o, p_rd_o, x_rd_o} !== 3'b000) begin
            err_cnt++; $display("FAIL %s.idle got %b exp 000", tag, {busy_o, p_rd_o, x_rd_o}); end
    endtask

    task automatic test_stray_out_valid();
        dp_out_valid_i  = 1'b1;
        dp_layer1_out_i = 16'h1234;
        step_cycle();
        step_cycle();
        vec_cnt++; if (res_we_o !== 1'b0) begin err_cnt++; $display("FAIL stray.res_we got %b exp 0", res_we_o); end
        vec_cnt++; if ({res_addr_o, res_data_o} !== 32'h0) begin
            err_cnt++; $display("FAIL stray.res got %h exp 0", {res_addr_o, res_data_o}); end
    endtask

    // Reload run; an extra start is pulsed in cycle stray_c (0 = none).
    task automatic test_reload_run(input int stray_c, input string tag);
        logic        e_prd, e_w1, e_b1, e_xrd, e_inv, e_we, e_busy, e_done;
        logic [15:0] e_paddr, e_xaddr, e_raddr, e_rdata;
        logic [31:0] e_nd, e_dx;
        run_id++;
        start_i  = 1'b1;
        reload_i = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step_cycle();
            start_i = (c == stray_c);
            e_prd   = (c >= 1) && (c <= 60);
            e_paddr = e_prd ? 16'(c - 1) : 16'h0;
            e_w1    = (c >= 2) && (c <= 51);
            e_b1    = (c >= 52) && (c <= 61);
            e_nd    = (e_w1 || e_b1) ? p_word(c - 2) : 32'h0;
            e_xrd   = (c >= 61) && (c <= 65);
            e_xaddr = e_xrd ? 16'(c - 61) : 16'h0;
            e_inv   = (c >= 62) && (c <= 66);
            e_dx    = e_inv ? x_word(c - 62) : 32'h0;
            e_we    = (c >= 68) && (c <= 77);
            e_raddr = e_we ? 16'(c - 68) : 16'h0;
            e_rdata = e_we ? res_val(run_id, c - 68) : 16'h0;
            e_busy  = (c >= 1) && (c <= 77);
            e_done  = (c == 78);
            vec_cnt++; if (p_rd_o !== e_prd) begin err_cnt++; $display("FAIL %s.p_rd c=%0d got %b exp %b", tag, c, p_rd_o, e_prd); end
            vec_cnt++; if (p_addr_o !== e_paddr) begin err_cnt++; $display("FAIL %s.p_addr c=%0d got %0d exp %0d", tag, c, p_addr_o, e_paddr); end
            vec_cnt++; if (dp_load_w1_o !== e_w1) begin err_cnt++; $display("FAIL %s.load_w1 c=%0d got %b exp %b", tag, c, dp_load_w1_o, e_w1); end
            vec_cnt++; if (dp_load_b1_o !== e_b1) begin err_cnt++; $display("FAIL %s.load_b1 c=%0d got %b exp %b", tag, c, dp_load_b1_o, e_b1); end
            vec_cnt++; if (dp_neuron_data_o !== e_nd) begin err_cnt++; $display("FAIL %s.neuron_data c=%0d got %h exp %h", tag, c, dp_neuron_data_o, e_nd); end
            vec_cnt++; if (x_rd_o !== e_xrd) begin err_cnt++; $display("FAIL %s.x_rd c=%0d got %b exp %b", tag, c, x_rd_o, e_xrd); end
            vec_cnt++; if (x_addr_o !== e_xaddr) begin err_cnt++; $display("FAIL %s.x_addr c=%0d got %0d exp %0d", tag, c, x_addr_o, e_xaddr); end
            vec_cnt++; if (dp_in_valid_o !== e_inv) begin err_cnt++; $display("FAIL %s.in_valid c=%0d got %b exp %b", tag, c, dp_in_valid_o, e_inv); end
            vec_cnt++; if (dp_x_o !== e_dx) begin err_cnt++; $display("FAIL %s.dp_x c=%0d got %h exp %h", tag, c, dp_x_o, e_dx); end
            vec_cnt++; if (res_we_o !== e_we) begin err_cnt++; $display("FAIL %s.res_we c=%0d got %b exp %b", tag, c, res_we_o, e_we); end
            vec_cnt++; if (res_addr_o !== e_raddr) begin err_cnt++; $display("FAIL %s.res_addr c=%0d got %0d exp %0d", tag, c, res_addr_o, e_raddr); end
            vec_cnt++; if (res_data_o !== e_rdata) begin err_cnt++; $display("FAIL %s.res_data c=%0d got %h exp %h", tag, c, res_data_o, e_rdata); end
            vec_cnt++; if (busy_o !== e_busy) begin err_cnt++; $display("FAIL %s.busy c=%0d got %b exp %b", tag, c, busy_o, e_busy); end
            vec_cnt++; if (done_o !== e_done) begin err_cnt++; $display("FAIL %s.done c=%0d got %b exp %b", tag, c, done_o, e_done); end
            vec_cnt++; if (err_o !== 1'b0) begin err_cnt++; $display("FAIL %s.err c=%0d got %b exp 0", tag, c, err_o); end
        end
        start_i = 1'b0;
    endtask

    // Infer-only run using previously loaded weights.
    task automatic test_infer_only(input string tag);
        logic        e_xrd, e_inv, e_we, e_busy, e_done;
        logic [15:0] e_xaddr, e_raddr, e_rdata;
        logic [31:0] e_dx;
        run_id++;
        start_i  = 1'b1;
        reload_i = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            step_cycle();
            start_i = 1'b0;
            e_xrd   = (c >= 1) && (c <= 5);
            e_xaddr = e_xrd ? 16'(c - 1) : 16'h0;
            e_inv   = (c >= 2) && (c <= 6);
            e_dx    = e_inv ? x_word(c - 2) : 32'h0;
            e_we    = (c >= 8) && (c <= 17);
            e_raddr = e_we ? 16'(c - 8) : 16'h0;
            e_rdata = e_we ? res_val(run_id, c - 8) : 16'h0;
            e_busy  = (c >= 1) && (c <= 17);
            e_done  = (c == 18);
            vec_cnt++; if ({p_rd_o, dp_load_w1_o, dp_load_b1_o} !== 3'b000) begin
                err_cnt++; $display("FAIL %s.param_activity c=%0d got %b exp 000", tag, c, {p_rd_o, dp_load_w1_o, dp_load_b1_o}); end
            vec_cnt++; if (dp_neuron_data_o !== 32'h0) begin err_cnt++; $display("FAIL %s.neuron_data c=%0d got %h exp 0", tag, c, dp_neuron_data_o); end
            vec_cnt++; if (x_rd_o !== e_xrd) begin err_cnt++; $display("FAIL %s.x_rd c=%0d got %b exp %b", tag, c, x_rd_o, e_xrd); end
            vec_cnt++; if (x_addr_o !== e_xaddr) begin err_cnt++; $display("FAIL %s.x_addr c=%0d got %0d exp %0d", tag, c, x_addr_o, e_xaddr); end
            vec_cnt++; if (dp_in_valid_o !== e_inv) begin err_cnt++; $display("FAIL %s.in_valid c=%0d got %b exp %b", tag, c, dp_in_valid_o, e_inv); end
            vec_cnt++; if (dp_x_o !== e_dx) begin err_cnt++; $display("FAIL %s.dp_x c=%0d got %h exp %h", tag, c, dp_x_o, e_dx); end
            vec_cnt++; if (res_we_o !== e_we) begin err_cnt++; $display("FAIL %s.res_we c=%0d got %b exp %b", tag, c, res_we_o, e_we); end
            vec_cnt++; if (res_addr_o !== e_raddr) begin err_cnt++; $display("FAIL %s.res_addr c=%0d got %0d exp %0d", tag, c, res_addr_o, e_raddr); end
            vec_cnt++; if (res_data_o !== e_rdata) begin err_cnt++; $display("FAIL %s.res_data c=%0d got %h exp %h", tag, c, res_data_o, e_rdata); end
            vec_cnt++; if (busy_o !== e_busy) begin err_cnt++; $display("FAIL %s.busy c=%0d got %b exp %b", tag, c, busy_o, e_busy); end
            vec_cnt++; if (done_o !== e_done) begin err_cnt++; $display("FAIL %s.done c=%0d got %b exp %b", tag, c, done_o, e_done); end
            vec_cnt++; if (err_o !== 1'b0) begin err_cnt++; $display("FAIL %s.err c=%0d got %b exp 0", tag, c, err_o); end
        end
    endtask

    task automatic test_back_to_back();
        test_infer_only("b2b_first");
        step_cycle();
        vec_cnt++; if ({busy_o, done_o} !== 2'b00) begin
            err_cnt++; $display("FAIL b2b.gap got %b exp 00", {busy_o, done_o}); end
        test_infer_only("b2b_second");
    endtask

    task automatic test_reset_mid_run();
        run_id++;
        start_i  = 1'b1;
        reload_i = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step_cycle();
            start_i = 1'b0;
        end
        vec_cnt++; if ({busy_o, p_rd_o, dp_load_w1_o} !== 3'b111) begin
            err_cnt++; $display("FAIL midrst.pre got %b exp 111", {busy_o, p_rd_o, dp_load_w1_o}); end
        rstn_i = 1'b0;
        step_cycle();
        rstn_i = 1'b1;
        vec_cnt++; if ({busy_o, done_o, err_o, p_rd_o, x_rd_o, dp_load_w1_o, dp_load_b1_o, dp_in_valid_o, res_we_o} !== 9'b0) begin
            err_cnt++; $display("FAIL midrst.flags got %b exp 0",
                {busy_o, done_o, err_o, p_rd_o, x_rd_o, dp_load_w1_o, dp_load_b1_o, dp_in_valid_o, res_we_o}); end
        vec_cnt++; if ({p_addr_o, x_addr_o, res_addr_o, res_data_o, dp_neuron_data_o, dp_x_o} !== 128'h0) begin
            err_cnt++; $display("FAIL midrst.buses got %h exp 0",
                {p_addr_o, x_addr_o, res_addr_o, res_data_o, dp_neuron_data_o, dp_x_o}); end
        for (int c = 0; c < 5; c++) begin
            step_cycle();
            vec_cnt++; if ({busy_o, done_o, p_rd_o} !== 3'b000) begin
                err_cnt++; $display("FAIL midrst.quiet c=%0d got %b exp 000", c, {busy_o, done_o, p_rd_o}); end
        end
        test_err_no_weights("midrst_err");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i          = 1'b0;
        start_i         = 1'b0;
        reload_i        = 1'b0;
        p_data_i        = 32'h0;
        x_data_i        = 32'h0;
        dp_out_valid_i  = 1'b0;
        dp_layer1_out_i = 16'h0;

        test_reset();
        test_err_no_weights("err_from_reset");
        test_stray_out_valid();
        step_cycle();
        test_reload_run(0, "reload");
        step_cycle();
        test_infer_only("infer");
        step_cycle();
        test_back_to_back();
        step_cycle();
        test_reload_run(20, "start_busy");
        step_cycle();
        test_reload_run(78, "start_in_done");
        test_reset_mid_run();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/half_layer1_sequencer.md
# half_layer1_sequencer

Sequencing controller for the half-precision layer-1 predict datapath (matrix-dot-vector, bias add, sigmoid). On `start` it optionally streams W1 and b1 from a parameter memory into the datapath. It then streams the input vector x from an input memory. It collects the LAYER2_NEURONS sigmoid outputs into a result buffer and signals `done`. It sits between the host-visible memories and the layer-1 datapath, and is the only driver of the datapath's load and valid strobes.

## Interface
- LAYER1_NEURONS, 10, input vector length (W1 width); must be a multiple of MULTS
- LAYER2_NEURONS, 10, output count (W1 height, bias length)
- MULTS, 2, words delivered per datapath beat
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- reload  in  1  sampled with start: 1 = load W1 and b1, then infer; 0 = infer only
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last result write
- err  out  1  one-cycle pulse when start has reload=0 and no weights have been loaded since reset
- p_rd, p_addr  out  1, 16  parameter memory read strobe and word-group address
- p_data  in  16×MULTS  parameter read data, valid the cycle after p_rd
- x_rd, x_addr  out  1, 16  input memory read strobe and address
- x_data  in  16×MULTS  input read data, valid the cycle after x_rd
- dp_load_W1, dp_load_b1, dp_in_valid  out  1 each  datapath strobes
- dp_neuron_data, dp_x  out  16×MULTS  datapath data lanes
- dp_out_valid  in  1  datapath result strobe
- dp_layer1_out  in  16  datapath result word
- res_we, res_addr, res_data  out  1, 16, 16  result buffer write port

## Operation
Definitions:
- W_BEATS = LAYER1_NEURONS·LAYER2_NEURONS/MULTS
- X_BEATS = LAYER1_NEURONS/MULTS

Parameter memory layout:
- W1 occupies addresses 0..W_BEATS-1, MULTS words per address.
- b1 occupies W_BEATS..W_BEATS+LAYER2_NEURONS-1, with only lane 0 used.

States:
- IDLE:
  - start with reload=1 → LOAD_W.
  - start with reload=0 and weights_valid=1 → RUN_X.
  - start with reload=0 and weights_valid=0 → pulse err, stay in IDLE.
- LOAD_W: issue p_rd for addresses 0..W_BEATS-1, one per cycle → LOAD_B.
- LOAD_B: issue p_rd for the LAYER2_NEURONS bias addresses → RUN_X. Set weights_valid.
- RUN_X: issue x_rd for addresses 0..X_BEATS-1, one per cycle → DRAIN.
- DRAIN: wait until LAYER2_NEURONS results have been written → DONE.
- DONE: pulse done for one cycle → IDLE.

Datapath strobes and data:
- dp_load_W1, dp_load_b1 and dp_in_valid are p_rd or x_rd delayed one cycle, qualified by the phase that issued the read.
- dp_neuron_data = p_data and dp_x = x_data, passed through in the data-valid cycle.
- Data lanes are zero whenever no strobe is high.

Result capture:
- Each dp_out_valid writes res_data = dp_layer1_out at res_addr = result count.
- The count increments per write and clears on accepted start.
- dp_out_valid outside RUN_X/DRAIN is ignored, with no write.

Persistence:
- weights_valid clears only on reset. Back-to-back infer-only runs reuse the loaded weights.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset is synchronous, so a mid-operation reset aborts at the next edge without a done pulse. The datapath shares rstn.
- Accepted start at cycle T: the first p_rd (or x_rd) is issued at T+1 and busy rises at T+1.
- Phases run back-to-back with no gap. The first read of a phase follows the cycle after the last read of the previous phase.
- Every datapath strobe is exactly one cycle after its read strobe. At most one strobe is high per cycle.
- Reload run: the last x_rd is at T+W_BEATS+LAYER2_NEURONS+X_BEATS.
- Infer-only run: the last x_rd is at T+X_BEATS.
- done is issued the cycle after the final res_we. busy falls in the same cycle done pulses.
- start is ignored while busy=1, including in the DONE cycle. A start in the cycle after done is accepted.
- dp_out_valid coinciding with the final count write: the write occurs and the DONE transition follows in the next cycle.

## Structure
- A shared package holds:
  - the state enum (IDLE, LOAD_W, LOAD_B, RUN_X, DRAIN, DONE)
  - the 16-bit half word typedef
  - localparam functions for W_BEATS and X_BEATS
- One natural sub-module is half_seq_addr_counter: a loadable counter with terminal-count flag, instantiated for the read address and the result count.
- The datapath is instantiated by the parent, not inside this block.

## Test plan
Bench uses the default parameters (10/10/2: W_BEATS=50, X_BEATS=5).

- **Reload run:** start with reload=1 at T.
  - p_rd is high at T+1..T+60, with addresses 0..59.
  - dp_load_W1 is high for 50 cycles, then dp_load_b1 for 10 cycles.
  - x_rd is high at T+61..T+65.
  - The datapath model returns 10 results; 10 res_we writes land at addresses 0..9.
  - done pulses one cycle after the 10th write.
- **Infer-only after reload:** start with reload=0. There is no p_rd activity, x_rd is high at T+1..T+5, and the results are rewritten.
- **Infer-only from reset:** start with reload=0 → err pulses once, busy stays 0, no reads.
- **Start while busy:** pulse start at T+20 during LOAD_W → ignored, and the original sequence timing is unchanged.
- **Reset mid-run:** rstn low at T+30 for one cycle.
  - All outputs are 0 at the next edge, with no done.
  - A subsequent start with reload=0 gives err, since weights_valid was cleared.
- **Stray dp_out_valid:** pulse dp_out_valid in IDLE → no res_we.
